soda_dispense_sequencer: RTL and testbench
==========================================

Name: soda_dispense_sequencer

Overview:
Sequences the physical dispense hardware behind soda_machine. It consumes soda_machine's one-cycle decision outputs (pour_water, change1, change2, change22) and queues them. It then drives the water valve and the two coin ejectors one at a time with fixed pulse and spacing timing. It raises busy so the coin front-end can block further inserts until all queued work is done.

Parameters:
POUR_CYCLES, 20, cycles valve_open stays asserted per pour (>=1)
EJECT_PULSE, 2, cycles an ejector output stays asserted per coin (>=1)
EJECT_GAP, 3, idle cycles after each coin pulse before the next action (>=1)
CNT_W, 3, width of each pending-coin counter (saturates at 2**CNT_W-1)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset_n  in  1  asynchronous, active-low reset
pour_req  in  1  one-cycle pulse, connect to soda_machine pour_water
change1_req  in  1  one-cycle pulse: return one value-1 coin
change2_req  in  1  one-cycle pulse: return one value-2 coin
change22_req  in  1  one-cycle pulse: return two value-2 coins
valve_open  out  1  water valve drive
eject1  out  1  value-1 coin ejector drive
eject2  out  1  value-2 coin ejector drive
busy  out  1  high while any work is pending or in progress
overflow  out  1  sticky: a request was lost to saturation

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. While reset_n=0: state=IDLE, all pending counters and flags are 0, and valve_open, eject1, eject2, busy and overflow are all 0 immediately (no clock edge needed).
- Pending storage: pour_pend flag, pend1[CNT_W-1:0], pend2[CNT_W-1:0].
- Request capture, all requests sampled at rising edge:
  - pour_req sets pour_pend.
  - change1_req adds 1 to pend1.
  - change2_req adds 1 to pend2. change22_req adds 2 to pend2. If both are high, pend2 gains 3.
  - A counter increment and a decrement at the same edge are applied as a net change.
- Saturation:
  - A counter saturates at its maximum value; any unit that does not fit sets overflow.
  - pour_req while pour_pend=1 also sets overflow.
  - overflow clears only on reset.
- States: IDLE, POUR, EJ1, EJ2, GAP.
- IDLE: acts on registered pending values, never on same-cycle inputs. Priority is pour, then value-1 coins, then value-2 coins.
  - If pour_pend=1: go to POUR and clear pour_pend.
  - Else if pend1!=0: go to EJ1 and decrement pend1.
  - Else if pend2!=0: go to EJ2 and decrement pend2.
  - Otherwise stay in IDLE.
- POUR: stays POUR_CYCLES cycles, then goes to IDLE. pour_req arriving during POUR sets pour_pend for a later pour and is not an overflow.
- EJ1 / EJ2: stay EJECT_PULSE cycles, then go to GAP.
- GAP: stays EJECT_GAP cycles, then goes to IDLE.
- Single shared timer, width $clog2 of the largest parameter, +1. It is reloaded on every state entry.
- Outputs are Moore, decoded from registered state:
  - valve_open = (state==POUR)
  - eject1 = (state==EJ1)
  - eject2 = (state==EJ2)
  - At most one of the three is ever high.
- busy = (state!=IDLE) | pour_pend | (pend1!=0) | (pend2!=0).
- Latency: for a request captured at edge t with the sequencer idle, busy rises after edge t. The drive output rises after edge t+1 and stays high exactly the configured number of cycles.
- Back-to-back actions: IDLE lasts exactly one cycle between actions whenever work is pending.
- Reset mid-operation: the action is abandoned and nothing resumes after reset_n returns high.

Decomposition:
- Package soda_machine_types (next to insert_type): add enum dispense_state_t {IDLE, POUR, EJ1, EJ2, GAP}.
- No further sub-module is required. Optional: soda_sat_counter, a saturating counter with an overflow flag, instantiated twice for pend1 and pend2.

Test Plan:
Bench parameters for all scenarios: POUR_CYCLES=4, EJECT_PULSE=2, EJECT_GAP=1, CNT_W=2.
- Pour only: pour_req pulse at edge t -> busy=1 from after edge t; valve_open=1 for exactly 4 cycles starting after edge t+1; then busy=0; eject1 and eject2 stay 0.
- Pour with two value-2 coins: pour_req and change22_req in the same cycle -> 4 cycles valve, then the eject2 pattern 2 high / 1 gap / 1 IDLE / 2 high / 1 gap; eject1 never high; overflow=0.
- Mixed coins: change1_req and change2_req in the same cycle -> eject1 pulses once (2 cycles) before eject2 pulses once (2 cycles); busy drops after the second gap.
- Queue during pour: change2_req pulse in the 2nd valve cycle -> valve pattern unchanged; one eject2 pulse follows the pour.
- Saturation: 4 change1_req pulses during a pour -> pend1 reaches 3 and overflow=1; exactly 3 eject1 pulses follow; overflow stays 1 until reset.
- Reset mid-operation: reset_n=0 during the first EJ2 cycle -> eject2 and busy drop to 0 with no clock edge; after reset_n=1, no further ejection occurs and overflow=0.

Source files
------------

// File: rtl/soda_dispense_sequencer_pkg.sv
// Shared types for the soda machine: dispense sequencer state encoding and
// the sizing helper used to dimension its shared timer.
package soda_machine_types;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POUR = 3'd1,
    EJ1  = 3'd2,
    EJ2  = 3'd3,
    GAP  = 3'd4
  } dispense_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soda_dispense_sequencer_if.sv
// Request/drive bundle between the soda_machine decision logic, the
// dispense sequencer and the valve/ejector hardware.
interface soda_dispense_sequencer_if;
  logic pour_req;
  logic change1_req;
  logic change2_req;
  logic change22_req;
  logic valve_open;
  logic eject1;
  logic eject2;
  logic busy;
  logic overflow;

  modport master (
    output pour_req, change1_req, change2_req, change22_req,
    input  valve_open, eject1, eject2, busy, overflow
  );

  modport slave (
    input  pour_req, change1_req, change2_req, change22_req,
    output valve_open, eject1, eject2, busy, overflow
  );
endinterface

// File: rtl/soda_dispense_sequencer_sat_counter.sv
// Pending-coin counter: adds 0..3 and removes 0..1 per edge as a net change,
// clamping at full scale and flagging units that did not fit.
module soda_sat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             lost
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] MAXV = SUM_W'((1 << CNT_W) - 1);

  logic [SUM_W-1:0] sum;

  // dec is only issued for a non-zero count, so sum never wraps below zero
  assign sum  = SUM_W'(count) + SUM_W'(inc) - SUM_W'(dec);
  assign lost = (sum > MAXV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= lost ? MAXV[CNT_W-1:0] : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/soda_dispense_sequencer.sv
// Queues pour/change decisions and plays them out one at a time on the water
// valve and the two coin ejectors with fixed pulse and gap timing.
module soda_dispense_sequencer
  import soda_machine_types::*;
#(
  parameter int POUR_CYCLES = 20,
  parameter int EJECT_PULSE = 2,
  parameter int EJECT_GAP   = 3,
  parameter int CNT_W       = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  soda_dispense_sequencer_if.slave  sif
);

  localparam int TMR_W = $clog2(max3(POUR_CYCLES, EJECT_PULSE, EJECT_GAP)) + 1;

  dispense_state_t  state;
  logic [TMR_W-1:0] timer;
  logic             pour_pend;
  logic             overflow_r;
  logic [CNT_W-1:0] pend1;
  logic [CNT_W-1:0] pend2;
  logic             lost1;
  logic             lost2;
  logic             take_pour;
  logic             take1;
  logic             take2;

  // IDLE picks from registered pending work only: pour, then value-1, then value-2
  assign take_pour = (state == IDLE) && pour_pend;
  assign take1     = (state == IDLE) && !pour_pend && (pend1 != '0);
  assign take2     = (state == IDLE) && !pour_pend && (pend1 == '0) && (pend2 != '0);

  soda_sat_counter #(.CNT_W(CNT_W)) u_pend1 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ({1'b0, sif.change1_req}),
    .dec     (take1),
    .count   (pend1),
    .lost    (lost1)
  );

  // change22 weighs 2 and change2 weighs 1, so the pair is the binary increment
  soda_sat_counter #(.CNT_W(CNT_W)) u_pend2 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ({sif.change22_req, sif.change2_req}),
    .dec     (take2),
    .count   (pend2),
    .lost    (lost2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      pour_pend  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      pour_pend <= sif.pour_req | (pour_pend & ~take_pour);
      if (lost1 || lost2 || (sif.pour_req && pour_pend && !take_pour))
        overflow_r <= 1'b1;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (take_pour) begin
            state <= POUR;
            timer <= TMR_W'(POUR_CYCLES - 1);
          end else if (take1) begin
            state <= EJ1;
            timer <= TMR_W'(EJECT_PULSE - 1);
          end else if (take2) begin
            state <= EJ2;
            timer <= TMR_W'(EJECT_PULSE - 1);
          end
        end
        POUR: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 1'b1;
        end
        EJ1, EJ2: begin
          if (timer == '0) begin
            state <= GAP;
            timer <= TMR_W'(EJECT_GAP - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.valve_open = (state == POUR);
  assign sif.eject1     = (state == EJ1);
  assign sif.eject2     = (state == EJ2);
  assign sif.busy       = (state != IDLE) || pour_pend || (pend1 != '0) || (pend2 != '0);
  assign sif.overflow   = overflow_r;

endmodule

// File: tb/tb_soda_dispense_sequencer.sv
// Directed and random request traffic against a cycle-level queue model of
// the dispense sequencer's visible outputs.
module tb_soda_dispense_sequencer;

  localparam int PC   = 4;
  localparam int EP   = 2;
  localparam int EG   = 1;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  soda_dispense_sequencer_if sif ();

  soda_dispense_sequencer #(
    .POUR_CYCLES (PC),
    .EJECT_PULSE (EP),
    .EJECT_GAP   (EG),
    .CNT_W       (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] dut_out;
  assign dut_out = {sif.valve_open, sif.eject1, sif.eject2, sif.busy, sif.overflow};

  // Model: pending work as plain counts, and the action being played out as a
  // queue of per-cycle {valve,eject1,eject2} patterns.
  bit         m_pp;
  int         m_p1;
  int         m_p2;
  bit         m_ovf;
  bit         cur_act;
  logic [2:0] cur_out;
  logic [2:0] act_q[$];

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%b expected=%b {valve,ej1,ej2,busy,ovf} at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] expected();
    logic b;
    b = cur_act || m_pp || (m_p1 != 0) || (m_p2 != 0);
    return {cur_out, b, m_ovf};
  endfunction

  task automatic model_reset();
    m_pp = 0; m_p1 = 0; m_p2 = 0; m_ovf = 0;
    cur_act = 0; cur_out = 3'b000;
    act_q.delete();
  endtask

  task automatic push_action(input logic [2:0] pat, input int on_cycles, input int gap_cycles);
    for (int i = 0; i < on_cycles; i++) act_q.push_back(pat);
    for (int i = 0; i < gap_cycles; i++) act_q.push_back(3'b000);
    cur_out = act_q.pop_front();
    cur_act = 1;
  endtask

  task automatic model_edge(input bit p, input bit c1, input bit c2, input bit c22);
    bit tp, t1, t2;
    int v;
    tp = 0; t1 = 0; t2 = 0;
    if (act_q.size() > 0) begin
      cur_out = act_q.pop_front();
    end else if (cur_act) begin
      cur_act = 0; cur_out = 3'b000;
    end else if (m_pp) begin
      tp = 1; push_action(3'b100, PC, 0);
    end else if (m_p1 > 0) begin
      t1 = 1; push_action(3'b010, EP, EG);
    end else if (m_p2 > 0) begin
      t2 = 1; push_action(3'b001, EP, EG);
    end
    if (p && m_pp && !tp) m_ovf = 1;
    m_pp = p || (m_pp && !tp);
    v = m_p1 - int'(t1) + int'(c1);
    if (v > MAXC) begin m_ovf = 1; v = MAXC; end
    m_p1 = v;
    v = m_p2 - int'(t2) + int'(c2) + 2 * int'(c22);
    if (v > MAXC) begin m_ovf = 1; v = MAXC; end
    m_p2 = v;
  endtask

  task automatic cycle(input bit p, input bit c1, input bit c2, input bit c22, input string tag);
    sif.pour_req     = p;
    sif.change1_req  = c1;
    sif.change2_req  = c2;
    sif.change22_req = c22;
    @(posedge clk);
    model_edge(p, c1, c2, c22);
    #1;
    chk(tag, dut_out, expected());
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, tag);
  endtask

  initial begin
    bit seen;
    sif.pour_req = 0; sif.change1_req = 0; sif.change2_req = 0; sif.change22_req = 0;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("reset_state", dut_out, 5'b00000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    cycle(1, 0, 0, 0, "pour_only");
    idle(8, "pour_only");

    cycle(1, 0, 0, 1, "pour_22");
    idle(16, "pour_22");

    cycle(0, 1, 1, 0, "mixed");
    idle(10, "mixed");

    cycle(1, 0, 0, 0, "q_pour");
    idle(2, "q_pour");
    cycle(0, 0, 1, 0, "q_pour");
    idle(10, "q_pour");

    cycle(1, 0, 0, 0, "sat");
    idle(1, "sat");
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, "sat");
    idle(20, "sat_drain");

    cycle(0, 0, 1, 0, "rst_mid");
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sif.eject2 === 1'b1) seen = 1;
      else cycle(0, 0, 0, 0, "rst_mid");
    end
    chk("ej2_seen", {4'b0000, seen}, 5'b00001);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async", dut_out, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(8, "post_rst");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, "random");
    end
    idle(60, "final_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
